// File: rtl/simon_sequencer.sv
// Purpose : Simon memory-game controller: grows a pseudo-random colour sequence, shows it, checks the replay.
// Latency : one cycle from a start/playerPressed strobe to the resulting state; outputs decode registered state only.
// Backpress: none; strobes are sampled only in the states that use them and are ignored everywhere else.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start               - one-cycle pulse: begin a new game (honoured in IDLE/LOSE/WIN)
//   playerNum/Pressed   - player's colour and its qualifying one-cycle strobe (honoured in PLAY)
//   simonTurn           - controller owns the display (ADD/SHOW/GAP)
//   simonNum/Pressed    - colour being shown; simonNum is 0 outside SHOW
//   level               - current sequence length
//   gameOver, win       - LOSE or WIN reached; win only for a full-length replay
// Optional build macro SIMON_TIMEOUT_EN: lose after 255 PLAY cycles with no press.
module simon_sequencer #(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] playerNum,
    input  logic       playerPressed,
    output logic       simonTurn,
    output logic [1:0] simonNum,
    output logic       simonPressed,
    output logic [5:0] level,
    output logic       gameOver,
    output logic       win
);

    localparam int PW   = $clog2(MAX_LEN);
    localparam int CMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, ADD, SHOW, GAP, PLAY, LOSE, WIN} state_t;

    state_t        state, stateNext;
    logic [7:0]    lfsr;
    logic [1:0]    seq [MAX_LEN];
    logic [5:0]    levelNext;
    logic [PW-1:0] ptr, ptrNext;
    logic [CW-1:0] cnt, cntNext;
    logic          seqWe;
    logic [5:0]    lastIdx;
    logic          atLast;
    logic [1:0]    curNum;

    assign lastIdx = level - 6'd1;
    assign atLast  = ({{(6-PW){1'b0}}, ptr} == lastIdx);
    assign curNum  = seq[ptr];

`ifdef SIMON_TIMEOUT_EN
    logic [7:0] idleCnt, idleCntNext;
`endif

    always_comb begin
        stateNext = state;
        levelNext = level;
        ptrNext   = ptr;
        cntNext   = cnt;
        seqWe     = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        idleCntNext = 8'd0;
`endif
        case (state)
            IDLE: begin
                if (start) stateNext = ADD;
            end
            ADD: begin
                seqWe     = 1'b1;
                levelNext = level + 6'd1;
                ptrNext   = '0;
                cntNext   = '0;
                stateNext = SHOW;
            end
            SHOW: begin
                if (cnt == CW'(SHOW_CYCLES - 1)) begin
                    cntNext   = '0;
                    stateNext = GAP;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cntNext = '0;
                    if (atLast) begin
                        ptrNext   = '0;
                        stateNext = PLAY;
                    end else begin
                        ptrNext   = ptr + 1'b1;
                        stateNext = SHOW;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            PLAY: begin
                if (playerPressed) begin
                    if (playerNum != curNum) begin
                        stateNext = LOSE;
                    end else if (!atLast) begin
                        ptrNext = ptr + 1'b1;
                    end else if (level == 6'(MAX_LEN)) begin
                        stateNext = WIN;
                    end else begin
                        stateNext = ADD;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                // The first PLAY cycle sees idleCnt==0, so the 255th idle cycle sees 254.
                else if (idleCnt == 8'd254) begin
                    stateNext = LOSE;
                end else begin
                    idleCntNext = idleCnt + 8'd1;
                end
`endif
            end
            LOSE, WIN: begin
                if (start) begin
                    levelNext = 6'd0;
                    stateNext = ADD;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= 6'd0;
            ptr   <= '0;
            cnt   <= '0;
            lfsr  <= 8'hA5;
        end else begin
            state <= stateNext;
            level <= levelNext;
            ptr   <= ptrNext;
            cnt   <= cntNext;
            // x^8+x^6+x^5+x^4+1, free-running in every state.
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

`ifdef SIMON_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idleCnt <= 8'd0;
        else        idleCnt <= idleCntNext;
    end
`endif

    // Sequence storage is deliberately left unreset; level gates what is valid.
    always_ff @(posedge clk) begin
        if (seqWe) seq[level[PW-1:0]] <= lfsr[1:0];
    end

    assign simonTurn    = (state == ADD) || (state == SHOW) || (state == GAP);
    assign simonPressed = (state == SHOW);
    assign simonNum     = (state == SHOW) ? curNum : 2'd0;
    assign gameOver     = (state == LOSE) || (state == WIN);
    assign win          = (state == WIN);

endmodule

// File: tb/tb_simon_sequencer.sv
module tb_simon_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] playerNum = 2'd0;
    logic       playerPressed = 1'b0;

    logic       simonTurn, simonPressed, gameOver, win;
    logic [1:0] simonNum;
    logic [5:0] level;
    logic       simonTurn2, simonPressed2, gameOver2, win2;
    logic [1:0] simonNum2;
    logic [5:0] level2;

    always #5 clk = ~clk;

    simon_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .playerNum(playerNum),
        .playerPressed(playerPressed), .simonTurn(simonTurn), .simonNum(simonNum),
        .simonPressed(simonPressed), .level(level), .gameOver(gameOver), .win(win)
    );

    // Short game sharing the same stimulus: wins where the main instance adds a third step.
    simon_sequencer #(.MAX_LEN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .playerNum(playerNum),
        .playerPressed(playerPressed), .simonTurn(simonTurn2), .simonNum(simonNum2),
        .simonPressed(simonPressed2), .level(level2), .gameOver(gameOver2), .win(win2)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         len = 0;
    logic [1:0] expSeq [16];

    // Rising edges seen since reset was last released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsrAt(input int k);
        logic [7:0] l = 8'hA5;
        for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    // Called at the falling edge inside the ADD cycle.
    task automatic addStep();
        logic [7:0] l;
        chk("add.turn", 32'(simonTurn), 32'd1);
        chk("add.pressed", 32'(simonPressed), 32'd0);
        l = lfsrAt(cyc);
        expSeq[len] = l[1:0];
        len++;
        @(negedge clk);
    endtask

    // Called at the falling edge of the first SHOW cycle; returns in the first PLAY cycle.
    task automatic checkShow(input bit noise);
        for (int s = 0; s < len; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk("show.pressed", 32'(simonPressed), 32'd1);
                chk("show.num", 32'(simonNum), 32'(expSeq[s]));
                chk("show.level", 32'(level), 32'(len));
                if (noise) begin
                    start = 1'b1;
                    playerPressed = 1'b1;
                    playerNum = expSeq[s] + 2'd1;
                end
                @(negedge clk);
            end
            for (int c = 0; c < 2; c++) begin
                chk("gap.pressed", 32'(simonPressed), 32'd0);
                chk("gap.num", 32'(simonNum), 32'd0);
                chk("gap.turn", 32'(simonTurn), 32'd1);
                if (noise) begin
                    start = !(s == len - 1 && c == 1);
                    playerPressed = start;
                end
                @(negedge clk);
            end
        end
        chk("play.turn", 32'(simonTurn), 32'd0);
        chk("play.level", 32'(level), 32'(len));
    endtask

    // Replays the whole sequence correctly; returns at the falling edge after the last press.
    task automatic playRound();
        for (int i = 0; i < len; i++) begin
            playerPressed = 1'b1;
            playerNum = expSeq[i];
            @(negedge clk);
            playerPressed = 1'b0;
            if (i < len - 1) begin
                chk("play.mid.turn", 32'(simonTurn), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.turn", 32'(simonTurn), 32'd0);
        chk("rst.pressed", 32'(simonPressed), 32'd0);
        chk("rst.num", 32'(simonNum), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.gameOver", 32'(gameOver), 32'd0);
        chk("rst.win", 32'(win), 32'd0);

        // Round 1: start in the first cycle after reset.
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("add1.level", 32'(level), 32'd0);
        addStep();
        checkShow(1'b0);
        playRound();

        // Round 2: two SHOW windows separated by a GAP.
        addStep();
        checkShow(1'b0);
        playRound();

        // Short instance has now replayed a full-length sequence.
        chk("win2.gameOver", 32'(gameOver2), 32'd1);
        chk("win2.win", 32'(win2), 32'd1);
        chk("win2.level", 32'(level2), 32'd2);
        chk("win2.turn", 32'(simonTurn2), 32'd0);
        addStep();
        chk("win2.hold", 32'(win2), 32'd1);

        // Round 3 with player strobes and start pulses thrown at SHOW/GAP.
        checkShow(1'b1);
        playerPressed = 1'b1;
        playerNum = expSeq[0];
        @(negedge clk);
        playerPressed = 1'b0;
        chk("r3.step1.gameOver", 32'(gameOver), 32'd0);
        chk("r3.step1.turn", 32'(simonTurn), 32'd0);
        @(negedge clk);
        playerPressed = 1'b1;
        playerNum = expSeq[1] + 2'd1;
        @(negedge clk);
        playerPressed = 1'b0;
        chk("lose.gameOver", 32'(gameOver), 32'd1);
        chk("lose.win", 32'(win), 32'd0);
        chk("lose.level", 32'(level), 32'd3);
        chk("lose.turn", 32'(simonTurn), 32'd0);
        playerPressed = 1'b1;
        playerNum = expSeq[1];
        @(negedge clk);
        playerPressed = 1'b0;
        repeat (2) @(negedge clk);
        chk("lose.hold.gameOver", 32'(gameOver), 32'd1);
        chk("lose.hold.level", 32'(level), 32'd3);

        // New game from LOSE.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart.level", 32'(level), 32'd0);
        len = 0;
        addStep();
        chk("restart.show.level", 32'(level), 32'd1);
        chk("restart.show.pressed", 32'(simonPressed), 32'd1);
        @(negedge clk);

        // Reset in the middle of SHOW takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst.pressed", 32'(simonPressed), 32'd0);
        chk("arst.num", 32'(simonNum), 32'd0);
        chk("arst.turn", 32'(simonTurn), 32'd0);
        chk("arst.level", 32'(level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle.turn", 32'(simonTurn), 32'd0);
        chk("idle.pressed", 32'(simonPressed), 32'd0);
        chk("idle.level", 32'(level), 32'd0);
        chk("idle.gameOver", 32'(gameOver), 32'd0);

        // Idle PLAY behaviour.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        len = 0;
        addStep();
        checkShow(1'b0);
`ifdef SIMON_TIMEOUT_EN
        repeat (254) @(negedge clk);
        chk("tmo.254.gameOver", 32'(gameOver), 32'd0);
        @(negedge clk);
        chk("tmo.255.gameOver", 32'(gameOver), 32'd1);
        chk("tmo.255.win", 32'(win), 32'd0);
`else
        repeat (1000) @(negedge clk);
        chk("wait.turn", 32'(simonTurn), 32'd0);
        chk("wait.gameOver", 32'(gameOver), 32'd0);
        chk("wait.level", 32'(level), 32'd1);
        playRound();
        chk("wait.add.turn", 32'(simonTurn), 32'd1);
        chk("wait.add.gameOver", 32'(gameOver), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
